// File: rtl/mem_ctrl.sv
// Byte-serial RAM port shared by IF fetch and MEM load/store (MEM wins ties); optional fetch flush under MEMCTRL_IF_FLUSH_EN.
// Reads complete n+2 cycles after acceptance, writes n+1; requesters hold req (stall_* high) until their done pulse.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
`ifdef MEMCTRL_IF_FLUSH_EN
    input  logic              if_flush,
`endif
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] rbuf_fin;
    logic              we;
    logic              is_mem;
    logic [2:0]        n;
    logic [2:0]        cnt;
    logic [2:0]        cnt_m1;
    logic [2:0]        end_cnt;
    logic              flush;
    logic              busy;
    logic              accept_mem;
    logic              accept_if;
    logic              last;
    logic              flush_busy;

`ifdef MEMCTRL_IF_FLUSH_EN
    assign flush = if_flush;
`else
    assign flush = 1'b0;
`endif

    assign busy       = (state == BUSY_IF) || (state == BUSY_MEM);
    assign accept_mem = (state == IDLE) && mem_req;
    assign accept_if  = (state == IDLE) && !mem_req && if_req && !flush;
    assign flush_busy = (state == BUSY_IF) && flush;
    // Reads stay busy one cycle past the last address to catch the trailing ram_din byte.
    assign end_cnt    = we ? (n - 3'd1) : n;
    assign last       = busy && (cnt == end_cnt);
    assign cnt_m1     = cnt - 3'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_mem)     state_nxt = BUSY_MEM;
                else if (accept_if) state_nxt = BUSY_IF;
            end
            BUSY_IF: begin
                if (flush)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            BUSY_MEM: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rbuf_fin = rbuf;
        rbuf_fin[{cnt_m1[1:0], 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        ram_addr = '0;
        ram_wr   = 1'b0;
        ram_dout = 8'h00;
        if (busy && (cnt < n)) begin
            ram_addr = base + {{(ADDR_W-3){1'b0}}, cnt};
            if (we) begin
                ram_wr   = 1'b1;
                ram_dout = wbuf[{cnt[1:0], 3'b000} +: 8];
            end
        end
    end

    assign if_done   = (state == DONE) && !is_mem;
    assign mem_done  = (state == DONE) && is_mem;
`ifdef MEMCTRL_IF_FLUSH_EN
    assign stall_if  = if_req & ~if_done & ~if_flush;
`else
    assign stall_if  = if_req & ~if_done;
`endif
    assign stall_mem = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            we        <= 1'b0;
            is_mem    <= 1'b0;
            n         <= 3'd0;
            cnt       <= 3'd0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept_mem) begin
                base   <= mem_addr;
                we     <= mem_we;
                wbuf   <= mem_wdata;
                is_mem <= 1'b1;
                n      <= (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
                cnt    <= 3'd0;
                rbuf   <= '0;
            end else if (accept_if) begin
                base   <= if_addr;
                we     <= 1'b0;
                is_mem <= 1'b0;
                n      <= 3'd4;
                cnt    <= 3'd0;
                rbuf   <= '0;
            end else if (flush_busy) begin
                cnt <= 3'd0;
            end else if (busy) begin
                cnt <= cnt + 3'd1;
                if (!we && (cnt != 3'd0)) begin
                    rbuf <= rbuf_fin;
                    if (last) begin
                        if (is_mem) mem_rdata <= rbuf_fin;
                        else        if_data   <= rbuf_fin;
                    end
                end
            end else if (state == DONE) begin
                cnt <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl against a byte-array RAM and transaction-level expectations.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        stall_if;
    logic        stall_mem;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_if  = '0;
    logic [31:0] exp_mem = '0;
    logic [7:0]  ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
`ifdef MEMCTRL_IF_FLUSH_EN
        .if_flush(if_flush),
`endif
        .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Synchronous byte RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] = ram_dout;
        ram_din <= rd(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = rd(a + 32'(i));
        return w;
    endfunction

    // One transaction from an idle controller; the cycle the request is driven is A (c=0).
    task automatic run_txn(input bit m, input bit w, input logic [1:0] len,
                           input logic [31:0] a, input logic [31:0] wd);
        int n;
        int dc;
        logic [31:0] exp;
        if (!m) w = 1'b0;
        n   = !m ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        exp = w ? 32'h0 : word_at(a, n);
        dc  = w ? n + 1 : n + 2;
        if (m) begin
            mem_req = 1'b1; mem_we = w; mem_len = len; mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int c = 0; c <= dc; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= n) chk("ram_addr", ram_addr, a + 32'(c - 1));
            if (c == 0 || c == dc) chk("ram_addr_idle", ram_addr, 32'h0);
            chk("ram_wr", {31'b0, ram_wr}, {31'b0, (w && c >= 1 && c <= n)});
            if (w && c >= 1 && c <= n) chk("ram_dout", {24'b0, ram_dout}, {24'b0, wd[8*(c-1) +: 8]});
            chk(m ? "mem_done" : "if_done", {31'b0, m ? mem_done : if_done}, {31'b0, c == dc});
            chk(m ? "if_done_idle" : "mem_done_idle", {31'b0, m ? if_done : mem_done}, 32'h0);
            chk(m ? "stall_mem" : "stall_if", {31'b0, m ? stall_mem : stall_if}, {31'b0, c < dc});
            if (c == dc) begin
                if (m && !w) exp_mem = exp;
                if (!m) exp_if = exp;
                chk("if_data", if_data, exp_if);
                chk("mem_rdata", mem_rdata, exp_mem);
            end
            step();
            if (c == 0) begin
                mem_addr = $urandom; mem_wdata = $urandom; mem_len = 2'($urandom);
                if_addr = $urandom;
                if (m) mem_we = ~w;
            end
            if (c == dc) begin
                if (m) mem_req = 1'b0;
                else if_req = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
        step(); step();
        @(negedge clk);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("rst_dones", {30'b0, if_done, mem_done}, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Instruction fetch 0x100
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
        run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0);
        chk("fetch_word", if_data, 32'h93000013);

        // Byte store and readback
        run_txn(1'b1, 1'b1, 2'b00, 32'h2003, 32'hAABBCCDD);
        run_txn(1'b1, 1'b0, 2'b00, 32'h2003, 32'h0);
        chk("store_readback", mem_rdata, 32'h000000DD);

        // Wrapping word load
        run_txn(1'b1, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0);

        // Simultaneous requests: MEM half first, then IF
        ram[32'h40] = 8'h34; ram[32'h41] = 8'h12;
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h40;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            chk("sim_mem_done", {31'b0, mem_done}, {31'b0, c == 4});
            chk("sim_if_done", {31'b0, if_done}, {31'b0, c == 11});
            chk("sim_stall_if", {31'b0, stall_if}, {31'b0, c < 11});
            if (c == 4) chk("sim_mem_rdata", mem_rdata, 32'h00001234);
            if (c >= 6 && c <= 9) chk("sim_if_addr", ram_addr, 32'h200 + 32'(c - 6));
            if (c == 11) chk("sim_if_data", if_data, word_at(32'h200, 4));
            step();
            if (c == 4) mem_req = 1'b0;
            if (c == 11) if_req = 1'b0;
        end
        exp_mem = 32'h00001234;
        exp_if  = word_at(32'h200, 4);

        // MEM request arriving mid-fetch waits for the fetch
        if_req = 1'b1; if_addr = 32'h300;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            chk("mid_if_done", {31'b0, if_done}, {31'b0, c == 6});
            chk("mid_mem_done", {31'b0, mem_done}, {31'b0, c == 13});
            if (c >= 2) chk("mid_stall_mem", {31'b0, stall_mem}, {31'b0, c < 13});
            if (c >= 8 && c <= 11) chk("mid_mem_addr", ram_addr, 32'h500 + 32'(c - 8));
            if (c == 13) chk("mid_mem_rdata", mem_rdata, word_at(32'h500, 4));
            step();
            if (c == 1) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'h500;
            end
            if (c == 6) if_req = 1'b0;
            if (c == 13) mem_req = 1'b0;
        end
        exp_if  = word_at(32'h300, 4);
        exp_mem = word_at(32'h500, 4);

        // Reset during a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h600; mem_wdata = $urandom;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) chk("rst_mid_wr_on", {31'b0, ram_wr}, 32'h1);
            if (c >= 4) begin
                chk("rst_mid_wr_off", {31'b0, ram_wr}, 32'h0);
                chk("rst_mid_addr", ram_addr, 32'h0);
                chk("rst_mid_done", {31'b0, mem_done}, 32'h0);
            end
            if (c == 4) chk("rst_mid_if_data", if_data, 32'h0);
            step();
            if (c == 2) begin rst = 1'b1; mem_req = 1'b0; end
            if (c == 3) rst = 1'b0;
        end
        exp_if = '0;
        exp_mem = '0;

`ifdef MEMCTRL_IF_FLUSH_EN
        // Fetch flushed at A+2; replacement fetch accepted at A+3
        if_req = 1'b1; if_addr = 32'h800;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            chk("fl_if_done", {31'b0, if_done}, {31'b0, c == 9});
            if (c == 2) chk("fl_stall_if", {31'b0, stall_if}, 32'h0);
            if (c >= 4 && c <= 7) chk("fl_addr", ram_addr, 32'h700 + 32'(c - 4));
            if (c == 8) chk("fl_hold", if_data, exp_if);
            if (c == 9) chk("fl_data", if_data, word_at(32'h700, 4));
            step();
            if (c == 1) if_flush = 1'b1;
            if (c == 2) begin if_flush = 1'b0; if_addr = 32'h700; end
            if (c == 9) if_req = 1'b0;
        end
        exp_if = word_at(32'h700, 4);
`endif

        // Random back-to-back traffic, some near the address wrap
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                            : 32'($urandom_range(0, 63));
            run_txn(1'($urandom), 1'($urandom), 2'($urandom), a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the MEM-stage load/store.
- Serialises 8/16/32-bit accesses into byte cycles, little-endian.
- Returns assembled read data to the requester.
- Raises per-requester stop requests that feed the pipeline stall controller.

Parameters:
ADDR_W, 32, width of all address ports
DATA_W, 32, width of requester data ports (fixed word = 4 bytes)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  IF fetch request, held until if_done
if_addr  in  ADDR_W  fetch byte address
if_data  out  DATA_W  fetched instruction word
if_done  out  1  one-cycle completion pulse, IF
mem_req  in  1  MEM access request, held until mem_done
mem_we  in  1  1=store, 0=load
mem_len  in  2  00 byte, 01 half, 11 word; 10 treated as word
mem_addr  in  ADDR_W  MEM byte address
mem_wdata  in  DATA_W  store data, byte 0 = bits 7:0
mem_rdata  out  DATA_W  load data, zero-extended
mem_done  out  1  one-cycle completion pulse, MEM
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid one cycle after ram_addr
stall_if  out  1  stop request for fetch path, to stall controller
stall_mem  out  1  stop request for MEM path, to stall controller

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - state=IDLE; all outputs 0: if_data, mem_rdata, if_done, mem_done, ram_addr, ram_wr, ram_dout.
  - Reset mid-transaction drops the transaction; ram_wr is 0 from the next edge.
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- Transaction length n: IF always n=4; MEM n = 1, 2 or 4 from mem_len.
- IDLE, acceptance cycle A:
  - mem_req=1 -> BUSY_MEM; else if_req=1 -> BUSY_IF; else stay.
  - Simultaneous requests: MEM wins.
  - Base address and direction are latched at A.
  - Requester inputs are ignored after A.
- Byte sequencing, byte counter k=0..n-1:
  - In cycle A+1+k, ram_addr = base+k, modulo 2^ADDR_W; wrap at 0xFFFFFFFF -> 0x00000000.
  - Read: ram_din is captured at A+2+k into byte lane k.
  - Write: ram_wr=1 and ram_dout = mem_wdata byte k during cycles A+1..A+n; ram_wr=0 at all other times.
- Completion:
  - Read: done pulses in cycle A+n+2, with if_data/mem_rdata valid in the same cycle.
  - Write: mem_done pulses in cycle A+n+1.
  - State is DONE during the pulse; no request is accepted in DONE. Next state is IDLE, so the earliest next acceptance is one cycle after done.
- Data hold: if_data and mem_rdata hold their last value until overwritten by the next completion of the same requester. Unused upper lanes of mem_rdata are 0.
- No preemption: a mem_req arriving during BUSY_IF waits until that fetch completes. After DONE, a pending MEM request wins over a pending IF request.
- ram_addr is 0 in IDLE and DONE.
- Stop requests (combinational):
  - stall_if = if_req & ~if_done
  - stall_mem = mem_req & ~mem_done
- Protocol requirements on requesters:
  - Requester deasserts req in the cycle it samples done; a req still high in DONE is ignored.
  - Address/data must be stable from req assertion through A.

Optional Feature:
- Macro: MEMCTRL_IF_FLUSH_EN.
- Defined:
  - Adds input if_flush (1 bit), driven on branch misprediction.
  - if_flush=1 in BUSY_IF -> next state IDLE; no if_done; if_data unchanged; byte counter cleared.
  - if_flush=1 in IDLE with if_req=1 and mem_req=0 -> the request is not accepted that cycle.
  - if_flush=1 in BUSY_MEM or DONE -> no effect.
  - stall_if = if_req & ~if_done & ~if_flush.
- Undefined: no port; every accepted fetch runs to completion.

Test Plan:
- IF word fetch: if_req=1, if_addr=0x100; RAM 0x100..0x103 = 13,00,00,93 -> ram_addr 0x100..0x103 at A+1..A+4; if_done at A+6; if_data=0x93000013; stall_if=1 for A..A+5.
- Byte store: mem_req=1, mem_we=1, mem_len=00, mem_addr=0x2003, mem_wdata=0xAABBCCDD -> single ram_wr cycle at A+1, ram_addr=0x2003, ram_dout=0xDD; mem_done at A+2.
- Simultaneous requests: if_req and mem_req both 1 at A, mem load half at 0x40 (bytes 34,12) -> MEM serviced first, mem_rdata=0x00001234 at A+4; IF accepted at A+5, if_done at A+11.
- MEM arrives mid-fetch: mem_req=1 at A+2 of an IF fetch -> if_done at A+6; MEM accepted A+7; stall_mem=1 from A+2 until mem_done.
- Wrap and reset: word load at 0xFFFFFFFE -> ram_addr FFFFFFFE, FFFFFFFF, 0, 1; separately rst=1 at A+3 of a word store -> next cycle ram_wr=0, state IDLE, no mem_done.
- With MEMCTRL_IF_FLUSH_EN: if_flush=1 at A+2 of a fetch -> IDLE at A+3, no if_done, next if_req accepted at A+3.
